// File: rtl/laser_controller_pkg.sv
//------------------------------------------------------------------------------
// laser_controller_pkg
// Shared game constants, colour codes and laser FSM state encodings.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package laser_controller_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int H_OFFSET      = 10;
  localparam int V_OFFSET      = 10;
  localparam int SHIP_WIDTH    = 32;
  localparam int SHIP_HEIGHT   = 30;

  typedef enum logic [2:0] {
    BACKGROUND = 3'd0,
    SPACESHIP  = 3'd1,
    ALIENS0    = 3'd2,
    ALIENS1    = 3'd3,
    ALIENS2    = 3'd4,
    ALIENS3    = 3'd5,
    LASER      = 3'd6,
    NONE       = 3'd7
  } color_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLY      = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/laser_controller_pixel_render.sv
//------------------------------------------------------------------------------
// laser_pixel_render
// Registered box compare of the current pixel against the laser rectangle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module laser_pixel_render
  import laser_controller_pkg::*;
#(
  parameter int LASER_WIDTH  = 4,
  parameter int LASER_HEIGHT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic [9:0] laser_x,
  input  logic [9:0] laser_y,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic [2:0] color
);

  localparam logic [10:0] HALF_W = 11'(LASER_WIDTH / 2);
  localparam logic [10:0] LEN    = 11'(LASER_HEIGHT);

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        in_box;

  // 11-bit compares keep hPos+HALF_W and laser_y+LEN from wrapping.
  always_comb begin
    h_ext  = {1'b0, hPos};
    v_ext  = {1'b0, vPos};
    x_ext  = {1'b0, laser_x};
    y_ext  = {1'b0, laser_y};
    in_box = active
           && (h_ext + HALF_W >= x_ext) && (h_ext < x_ext + HALF_W)
           && (v_ext >= y_ext) && (v_ext < y_ext + LEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      color <= NONE;
    end else begin
      color <= in_box ? LASER : NONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/laser_controller.sv
//------------------------------------------------------------------------------
// laser_controller
// Single-shot laser sequencer (IDLE/FLY/COOLDOWN) with registered pixel colour.
// Optional macro LASER_AUTOFIRE_EN: level-sensitive fire (auto re-launch).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module laser_controller
  import laser_controller_pkg::*;
#(
  parameter int LASER_WIDTH     = 4,
  parameter int LASER_HEIGHT    = 12,
  parameter int LASER_SPEED     = 8,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [9:0] gunPosition,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic       laser_active,
  output logic [9:0] laser_x,
  output logic [9:0] laser_y,
  output logic       shot_fired,
  output logic [2:0] color
);

  localparam logic [9:0]  START_Y   = 10'(V_OFFSET + SHIP_HEIGHT);
  localparam logic [10:0] Y_LIMIT   = 11'(SCREEN_HEIGHT - V_OFFSET);
  localparam logic [10:0] Y_SPAN    = 11'(LASER_HEIGHT + LASER_SPEED);
  localparam logic [9:0]  Y_STEP    = 10'(LASER_SPEED);
  localparam logic [7:0]  COOL_LAST = 8'(COOLDOWN_FRAMES);

  state_t     state;
  state_t     state_d;
  logic [9:0] x_d;
  logic [9:0] y_d;
  logic       active_d;
  logic       shot_d;
  logic [7:0] cool_cnt;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic       fire_q;
  logic       fire_req;
  logic       at_edge;

`ifdef LASER_AUTOFIRE_EN
  assign fire_req = fire;
`else
  assign fire_req = fire & ~fire_q;
`endif

  assign cnt_inc = cool_cnt + 8'd1;
  // Would the next step push the laser's far end past the bottom border?
  assign at_edge = ({1'b0, laser_y} + Y_SPAN) > Y_LIMIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      laser_x      <= '0;
      laser_y      <= '0;
      laser_active <= 1'b0;
      shot_fired   <= 1'b0;
      cool_cnt     <= '0;
      fire_q       <= 1'b0;
    end else begin
      state        <= state_d;
      laser_x      <= x_d;
      laser_y      <= y_d;
      laser_active <= active_d;
      shot_fired   <= shot_d;
      cool_cnt     <= cnt_d;
      fire_q       <= fire;
    end
  end

  always_comb begin
    state_d  = state;
    x_d      = laser_x;
    y_d      = laser_y;
    active_d = laser_active;
    shot_d   = 1'b0;
    cnt_d    = cool_cnt;
    case (state)
      ST_IDLE: begin
        if (fire_req) begin
          state_d  = ST_FLY;
          x_d      = gunPosition;
          y_d      = START_Y;
          active_d = 1'b1;
          shot_d   = 1'b1;
        end
      end
      ST_FLY: begin
        if (hit || (frame_tick && at_edge)) begin
          state_d  = ST_COOLDOWN;
          active_d = 1'b0;
          cnt_d    = '0;
        end else if (frame_tick) begin
          y_d = laser_y + Y_STEP;
        end
      end
      ST_COOLDOWN: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == COOL_LAST) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  laser_pixel_render #(
    .LASER_WIDTH  (LASER_WIDTH),
    .LASER_HEIGHT (LASER_HEIGHT)
  ) u_render (
    .clk     (clk),
    .reset   (reset),
    .active  (laser_active),
    .laser_x (laser_x),
    .laser_y (laser_y),
    .hPos    (hPos),
    .vPos    (vPos),
    .color   (color)
  );

endmodule

`default_nettype wire

// File: tb/tb_laser_controller.sv
//------------------------------------------------------------------------------
// tb_laser_controller
// Directed scenarios plus randomized traffic against a behavioural shot model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_laser_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fire = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] gunPosition = '0;
  logic [9:0] hPos = '0;
  logic [9:0] vPos = '0;
  logic       laser_active;
  logic [9:0] laser_x;
  logic [9:0] laser_y;
  logic       shot_fired;
  logic [2:0] color;

  int total = 0;
  int bad = 0;
  int shots_seen = 0;

  // Model: mode 0 = waiting, 1 = shot in the air, 2 = recharging.
  int m_mode = 0;
  int m_x = 0;
  int m_y = 0;
  int m_ticks = 0;
  int m_prev_fire = 0;
  int m_shot = 0;
  int m_color = 7;

  laser_controller dut (
    .clk          (clk),
    .reset        (reset),
    .fire         (fire),
    .frame_tick   (frame_tick),
    .hit          (hit),
    .gunPosition  (gunPosition),
    .hPos         (hPos),
    .vPos         (vPos),
    .laser_active (laser_active),
    .laser_x      (laser_x),
    .laser_y      (laser_y),
    .shot_fired   (shot_fired),
    .color        (color)
  );

  always #5 clk = ~clk;

  // Applies one clock of game rules to the model using the inputs seen at the edge.
  function automatic void model_update();
    int want;
    int h;
    int v;
    h = int'(hPos);
    v = int'(vPos);
    m_color = (m_mode == 1 && h + 2 >= m_x && h < m_x + 2 && v >= m_y && v < m_y + 12) ? 6 : 7;
`ifdef LASER_AUTOFIRE_EN
    want = int'(fire);
`else
    want = (fire && !m_prev_fire) ? 1 : 0;
`endif
    m_shot = 0;
    if (reset) begin
      m_mode = 0; m_x = 0; m_y = 0; m_ticks = 0; m_color = 7;
    end else if (m_mode == 0) begin
      if (want != 0) begin
        m_mode = 1; m_x = int'(gunPosition); m_y = 40; m_shot = 1;
      end
    end else if (m_mode == 1) begin
      if (hit) begin
        m_mode = 2; m_ticks = 0;
      end else if (frame_tick) begin
        if (m_y + 12 + 8 > 470) begin
          m_mode = 2; m_ticks = 0;
        end else begin
          m_y = m_y + 8;
        end
      end
    end else begin
      if (frame_tick) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == 15) m_mode = 0;
      end
    end
    m_prev_fire = reset ? 0 : int'(fire);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    model_update();
    if (shot_fired === 1'b1) shots_seen++;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    total++;
    if ({laser_active, laser_x, laser_y, shot_fired, color} !== {1'b0, 10'd0, 10'd0, 1'b0, 3'd7}) begin
      bad++;
      $display("FAIL reset: act=%0b x=%0d y=%0d shot=%0b color=%0d want 0/0/0/0/7",
               laser_active, laser_x, laser_y, shot_fired, color);
    end
    reset = 1'b0;
  endtask

  task automatic test_launch();
    gunPosition = 10'd320;
    cyc();
    fire = 1'b1;
    cyc();
    total++;
    if ({laser_active, laser_x, laser_y, shot_fired} !== {1'b1, 10'd320, 10'd40, 1'b1}) begin
      bad++;
      $display("FAIL launch: act=%0b x=%0d y=%0d shot=%0b want 1/320/40/1",
               laser_active, laser_x, laser_y, shot_fired);
    end
    cyc();
    total++;
    if (shot_fired !== 1'b0) begin
      bad++;
      $display("FAIL launch_pulse: shot=%0b want 0", shot_fired);
    end
    fire = 1'b0;
  endtask

  task automatic test_flight_pixels();
    repeat (3) tick();
    total++;
    if (laser_y !== 10'd64) begin
      bad++;
      $display("FAIL fly_y: got %0d want 64", laser_y);
    end
    hPos = 10'd320; vPos = 10'd64;
    cyc();
    total++;
    if (color !== 3'd6) begin bad++; $display("FAIL pix_on: got %0d want 6", color); end
    hPos = 10'd322;
    cyc();
    total++;
    if (color !== 3'd7) begin bad++; $display("FAIL pix_right: got %0d want 7", color); end
    hPos = 10'd320; vPos = 10'd76;
    cyc();
    total++;
    if (color !== 3'd7) begin bad++; $display("FAIL pix_below: got %0d want 7", color); end
    gunPosition = 10'd100;
    cyc();
    cyc();
    total++;
    if (laser_x !== 10'd320) begin bad++; $display("FAIL x_latched: got %0d want 320", laser_x); end
  endtask

  task automatic test_hit_cooldown();
    hit = 1'b1; frame_tick = 1'b1;
    cyc();
    hit = 1'b0; frame_tick = 1'b0;
    total++;
    if ({laser_active, laser_y} !== {1'b0, 10'd64}) begin
      bad++;
      $display("FAIL hit: act=%0b y=%0d want 0/64", laser_active, laser_y);
    end
    for (int i = 0; i < 14; i++) begin
      fire = 1'b1; frame_tick = 1'b1;
      cyc();
      fire = 1'b0; frame_tick = 1'b0;
      cyc();
      total++;
      if (shot_fired !== 1'b0 || laser_active !== 1'b0) begin
        bad++;
        $display("FAIL cool_ignore[%0d]: shot=%0b act=%0b want 0/0", i, shot_fired, laser_active);
      end
    end
    tick();
    fire = 1'b1;
    cyc();
    total++;
    if ({shot_fired, laser_active, laser_x, laser_y} !== {1'b1, 1'b1, 10'd100, 10'd40}) begin
      bad++;
      $display("FAIL relaunch: shot=%0b act=%0b x=%0d y=%0d want 1/1/100/40",
               shot_fired, laser_active, laser_x, laser_y);
    end
    fire = 1'b0;
  endtask

  task automatic test_miss();
    repeat (52) tick();
    total++;
    if ({laser_active, laser_y} !== {1'b1, 10'd456}) begin
      bad++;
      $display("FAIL miss_last: act=%0b y=%0d want 1/456", laser_active, laser_y);
    end
    tick();
    total++;
    if ({laser_active, laser_y} !== {1'b0, 10'd456}) begin
      bad++;
      $display("FAIL miss_retire: act=%0b y=%0d want 0/456", laser_active, laser_y);
    end
    repeat (15) tick();
  endtask

  task automatic test_fire_held();
    int want_shots;
`ifdef LASER_AUTOFIRE_EN
    want_shots = 3;
`else
    want_shots = 1;
`endif
    shots_seen = 0;
    fire = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      repeat (14) tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      total++;
`ifdef LASER_AUTOFIRE_EN
      if (shot_fired !== 1'b1) begin bad++; $display("FAIL autofire[%0d]: shot=%0b want 1", k, shot_fired); end
`else
      if (shot_fired !== 1'b0) begin bad++; $display("FAIL held[%0d]: shot=%0b want 0", k, shot_fired); end
`endif
      cyc();
      cyc();
    end
    total++;
    if (shots_seen != want_shots) begin
      bad++;
      $display("FAIL held_count: got %0d want %0d", shots_seen, want_shots);
    end
    fire = 1'b0;
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_reset_midflight();
    gunPosition = 10'd320;
    cyc();
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    repeat (10) tick();
    total++;
    if (laser_y !== 10'd120) begin bad++; $display("FAIL pre_reset_y: got %0d want 120", laser_y); end
    hPos = 10'd320; vPos = 10'd120;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if ({laser_active, laser_y, shot_fired, color} !== {1'b0, 10'd0, 1'b0, 3'd7}) begin
      bad++;
      $display("FAIL mid_reset: act=%0b y=%0d shot=%0b color=%0d want 0/0/0/7",
               laser_active, laser_y, shot_fired, color);
    end
    cyc();
    total++;
    if ({laser_active, shot_fired, color} !== {1'b0, 1'b0, 3'd7}) begin
      bad++;
      $display("FAIL post_reset: act=%0b shot=%0b color=%0d want 0/0/7", laser_active, shot_fired, color);
    end
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    total++;
    if ({shot_fired, laser_x, laser_y} !== {1'b1, 10'd320, 10'd40}) begin
      bad++;
      $display("FAIL reset_relaunch: shot=%0b x=%0d y=%0d want 1/320/40", shot_fired, laser_x, laser_y);
    end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      frame_tick = ($urandom_range(0, 2) == 0);
      hit = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 15) == 0) gunPosition = 10'($urandom_range(0, 639));
      if ($urandom_range(0, 1) == 0) begin
        hPos = 10'(m_x + int'($urandom_range(0, 7)) - 4);
        vPos = 10'(m_y + int'($urandom_range(0, 15)) - 2);
      end else begin
        hPos = 10'($urandom_range(0, 639));
        vPos = 10'($urandom_range(0, 479));
      end
      cyc();
      total++;
      if (laser_active !== (m_mode == 1) || laser_x !== 10'(m_x) || laser_y !== 10'(m_y)
          || shot_fired !== 1'(m_shot) || color !== 3'(m_color)) begin
        bad++;
        if (errs < 10)
          $display("FAIL random[%0d]: act=%0b x=%0d y=%0d shot=%0b color=%0d want %0b/%0d/%0d/%0d/%0d",
                   n, laser_active, laser_x, laser_y, shot_fired, color,
                   (m_mode == 1), m_x, m_y, m_shot, m_color);
        errs++;
      end
    end
    reset = 1'b0;
    fire = 1'b0;
    hit = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_flight_pixels();
    test_hit_cooldown();
    test_miss();
    test_fire_held();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
